// File: rtl/ldst_control_sequencer.sv
// ============================================================================
// Module   : ldst_control_sequencer
// Purpose  : Hardwired fetch/ld/ldi/st control-step sequencer with memory
//            wait-state handshake, wait timeout and illegal-opcode detection.
// Option   : define LDST_ILLEGAL_TRAP_EN to park in TRAP on an illegal opcode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ldst_control_sequencer #(
  parameter int              OPW        = 5,
  parameter logic [OPW-1:0]  OPC_LD     = 5'b00000,
  parameter logic [OPW-1:0]  OPC_LDI    = 5'b00001,
  parameter logic [OPW-1:0]  OPC_ST     = 5'b00010,
  parameter int              WAIT_LIMIT = 15
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [OPW-1:0] operation,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           ZHighIn,
  output logic           ZLowIn,
  output logic           ZLowout,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           GRA,
  output logic           GRB,
  output logic           Baout,
  output logic           Yin,
  output logic           Cout,
  output logic           R_in,
  output logic           R_out,
  output logic           RAM_write_en,
  output logic [3:0]     step,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic           illegal
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] C_LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_T0   = 4'h0,
    S_T1   = 4'h1,
    S_T2   = 4'h2,
    S_T3   = 4'h3,
    S_T4   = 4'h4,
    S_T5   = 4'h5,
    S_T6   = 4'h6,
    S_T7   = 4'h7,
    S_TRAP = 4'hE,
    S_IDLE = 4'hF
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0] op_q, op_d;

  logic   w_wait;
  logic   w_limit;
  logic   w_legal_in;
  state_t w_end;

  assign w_wait     = (state_q == S_T1) ||
                      ((state_q == S_T6) && (op_q == OPC_LD)) ||
                      ((state_q == S_T7) && (op_q == OPC_ST));
  // Ready in the limit cycle wins, so the abort needs mem_ready low as well.
  assign w_limit    = w_wait && !mem_ready && (cnt_q == C_LIMIT_M1);
  assign w_legal_in = (operation == OPC_LD) || (operation == OPC_LDI) ||
                      (operation == OPC_ST);
  assign w_end      = run ? S_T0 : S_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    op_d    = op_q;
    if (w_wait && !mem_ready) begin
      if (w_limit) state_d = S_IDLE;
      else         cnt_d   = cnt_q + CW'(1);
    end else begin
      case (state_q)
        S_IDLE: if (run) state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   state_d = S_T2;
        S_T2:   state_d = S_T3;
        S_T3: begin
          op_d = operation;
          if (w_legal_in) state_d = S_T4;
`ifdef LDST_ILLEGAL_TRAP_EN
          else            state_d = S_TRAP;
`else
          else            state_d = w_end;
`endif
        end
        S_T4:   state_d = S_T5;
        S_T5:   state_d = (op_q == OPC_LDI) ? w_end : S_T6;
        S_T6:   state_d = S_T7;
        S_T7:   state_d = w_end;
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
    ZLowout = 1'b0; PCin = 1'b0; Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; GRA = 1'b0; GRB = 1'b0; Baout = 1'b0; Yin = 1'b0; Cout = 1'b0;
    R_in = 1'b0; R_out = 1'b0; RAM_write_en = 1'b0;
    done    = 1'b0;
    timeout = w_limit;
    illegal = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
      end
      S_T1: if (!w_limit) begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (w_legal_in) begin
          GRB = 1'b1; Baout = 1'b1; Yin = 1'b1;
        end else begin
          illegal = 1'b1;
`ifndef LDST_ILLEGAL_TRAP_EN
          done    = 1'b1;
`endif
        end
      end
      S_T4: begin
        Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (op_q == OPC_LDI) begin
          GRA = 1'b1; R_in = 1'b1; done = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        if (op_q == OPC_LD) begin
          if (!w_limit) begin
            Read = 1'b1; MDRin = 1'b1;
          end
        end else begin
          GRA = 1'b1; R_out = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (op_q == OPC_LD) begin
          MDRout = 1'b1; GRA = 1'b1; R_in = 1'b1; done = 1'b1;
        end else if (!w_limit) begin
          MDRout = 1'b1; RAM_write_en = 1'b1; done = mem_ready;
        end
      end
`ifdef LDST_ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign step = state_q;
  assign busy = (state_q != S_IDLE) && (state_q != S_TRAP);

endmodule

`default_nettype wire

// File: tb/tb_ldst_control_sequencer.sv
// ============================================================================
// Module   : tb_ldst_control_sequencer
// Purpose  : Randomized instruction streams against a transaction-level plan
//            of the expected per-cycle control trace.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ldst_control_sequencer;

  localparam int WL = 15;
  localparam logic [4:0] C_LD  = 5'b00000;
  localparam logic [4:0] C_LDI = 5'b00001;
  localparam logic [4:0] C_ST  = 5'b00010;

  localparam logic [18:0] M_PCOUT   = 19'd1 << 18;
  localparam logic [18:0] M_MARIN   = 19'd1 << 17;
  localparam logic [18:0] M_INCPC   = 19'd1 << 16;
  localparam logic [18:0] M_ZHI     = 19'd1 << 15;
  localparam logic [18:0] M_ZLO     = 19'd1 << 14;
  localparam logic [18:0] M_ZLOWOUT = 19'd1 << 13;
  localparam logic [18:0] M_PCIN    = 19'd1 << 12;
  localparam logic [18:0] M_READ    = 19'd1 << 11;
  localparam logic [18:0] M_MDRIN   = 19'd1 << 10;
  localparam logic [18:0] M_MDROUT  = 19'd1 << 9;
  localparam logic [18:0] M_IRIN    = 19'd1 << 8;
  localparam logic [18:0] M_GRA     = 19'd1 << 7;
  localparam logic [18:0] M_GRB     = 19'd1 << 6;
  localparam logic [18:0] M_BAOUT   = 19'd1 << 5;
  localparam logic [18:0] M_YIN     = 19'd1 << 4;
  localparam logic [18:0] M_COUT    = 19'd1 << 3;
  localparam logic [18:0] M_RIN     = 19'd1 << 2;
  localparam logic [18:0] M_ROUT    = 19'd1 << 1;
  localparam logic [18:0] M_RAMW    = 19'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, run, mem_ready;
  logic [4:0] operation;
  logic PCout, MARin, IncPC, ZHighIn, ZLowIn, ZLowout, PCin, Read, MDRin, MDRout;
  logic IRin, GRA, GRB, Baout, Yin, Cout, R_in, R_out, RAM_write_en;
  logic [3:0] step;
  logic busy, done, timeout, illegal;

  ldst_control_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .clr(clr), .run(run), .operation(operation), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .ZLowout(ZLowout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .GRA(GRA), .GRB(GRB), .Baout(Baout), .Yin(Yin), .Cout(Cout),
    .R_in(R_in), .R_out(R_out), .RAM_write_en(RAM_write_en), .step(step),
    .busy(busy), .done(done), .timeout(timeout), .illegal(illegal)
  );

  logic [26:0] obs;
  assign obs = {PCout, MARin, IncPC, ZHighIn, ZLowIn, ZLowout, PCin, Read, MDRin,
                MDRout, IRin, GRA, GRB, Baout, Yin, Cout, R_in, R_out, RAM_write_en,
                step, busy, done, timeout, illegal};

  typedef struct {
    logic        clr;
    logic        run;
    logic        mr;
    logic [4:0]  op;
    logic [26:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  bit stop, idle_m, rst_en;
  int rst_step;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic int pick_wait();
    int r = $urandom_range(0, 15);
    if (r < 10) return $urandom_range(0, 3);
    if (r < 13) return WL - 1;
    return WL + $urandom_range(0, 2);
  endfunction

  task automatic push(input int stp, input logic [18:0] ctl, input logic mr,
                      input logic [4:0] op, input logic rn, input logic dn,
                      input logic tm, input logic il);
    cyc_t c;
    if (stop) return;
    c.clr = 1'b1; c.run = rn; c.mr = mr; c.op = op;
    c.exp = {ctl, 4'(stp), (stp <= 7), dn, tm, il};
    if (rst_en && stp == rst_step) begin
      c.clr = 1'b0; stop = 1; idle_m = 1; rst_en = 0;
    end
    q.push_back(c);
  endtask

  // A memory step: nready not-ready cycles, then one ready cycle, unless the
  // wait limit is hit first.
  task automatic do_wait(input int stp, input logic [18:0] ctl, input int nready,
                         input logic fin_done, input logic run_after);
    for (int i = 0; !stop; i++) begin
      if (i < nready) begin
        if (i == WL - 1) begin
          push(stp, '0, 1'b0, rop(), rb(), 1'b0, 1'b1, 1'b0);
          stop = 1; idle_m = 1;
        end else begin
          push(stp, ctl, 1'b0, rop(), rb(), 1'b0, 1'b0, 1'b0);
        end
      end else begin
        push(stp, ctl, 1'b1, rop(), fin_done ? run_after : rb(), fin_done, 1'b0, 1'b0);
        break;
      end
    end
  endtask

  task automatic plan(input logic [4:0] op, input int wf, input int wm,
                      input logic run_after, input int rstep);
    logic legal;
    stop = 0; rst_en = (rstep >= 0); rst_step = rstep;
    if (idle_m) begin
      int k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) push(15, '0, rb(), rop(), 1'b0, 1'b0, 1'b0, 1'b0);
      push(15, '0, rb(), rop(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (stop) return;
      idle_m = 0;
    end
    push(0, M_PCOUT | M_MARIN | M_INCPC | M_ZHI | M_ZLO, rb(), rop(), rb(), 0, 0, 0);
    do_wait(1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, wf, 1'b0, 1'b0);
    if (stop) return;
    push(2, M_MDROUT | M_IRIN, rb(), rop(), rb(), 0, 0, 0);
    legal = (op == C_LD) || (op == C_LDI) || (op == C_ST);
    if (!legal) begin
`ifdef LDST_ILLEGAL_TRAP_EN
      push(3, '0, rb(), op, rb(), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) push(14, '0, rb(), rop(), rb(), 1'b0, 1'b0, 1'b1);
      if (!stop) begin
        push(14, '0, rb(), rop(), rb(), 1'b0, 1'b0, 1'b1);
        q[q.size() - 1].clr = 1'b0;
      end
      stop = 1; idle_m = 1;
`else
      push(3, '0, rb(), op, run_after, 1'b1, 1'b0, 1'b1);
      if (!stop) idle_m = !run_after;
`endif
      return;
    end
    push(3, M_GRB | M_BAOUT | M_YIN, rb(), op, rb(), 0, 0, 0);
    push(4, M_COUT | M_ZHI | M_ZLO, rb(), rop(), rb(), 0, 0, 0);
    if (op == C_LDI) begin
      push(5, M_ZLOWOUT | M_GRA | M_RIN, rb(), rop(), run_after, 1'b1, 1'b0, 1'b0);
      if (!stop) idle_m = !run_after;
      return;
    end
    push(5, M_ZLOWOUT | M_MARIN, rb(), rop(), rb(), 0, 0, 0);
    if (op == C_LD) begin
      do_wait(6, M_READ | M_MDRIN, wm, 1'b0, 1'b0);
      if (stop) return;
      push(7, M_MDROUT | M_GRA | M_RIN, rb(), rop(), run_after, 1'b1, 1'b0, 1'b0);
    end else begin
      push(6, M_GRA | M_ROUT | M_MDRIN, rb(), rop(), rb(), 0, 0, 0);
      do_wait(7, M_MDROUT | M_RAMW, wm, 1'b1, run_after);
    end
    if (!stop) idle_m = !run_after;
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; operation = '0; mem_ready = 1'b0;
    idle_m = 1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset", 32'(obs), {5'd0, 19'd0, 4'hF, 4'b0000});

    plan(C_LD,  0, 0, 1'b1, -1);
    plan(C_ST,  0, 3, 1'b1, -1);
    plan(C_LDI, 0, 0, 1'b1, -1);
    plan(C_LD,  WL, 0, 1'b0, -1);
    plan(C_LD,  WL - 1, WL - 1, 1'b1, -1);
    plan(C_ST,  0, WL, 1'b1, -1);
    plan(5'b11111, 0, 0, 1'b1, -1);
    plan(C_ST,  0, 0, 1'b1, 6);
    plan(C_LD,  0, 0, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      logic [4:0] op;
      int r = $urandom_range(0, 7);
      op = (r == 0) ? rop() : ((r < 3) ? C_LD : ((r < 5) ? C_LDI : C_ST));
      plan(op, pick_wait(), pick_wait(), rb(),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
    end

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      clr = q[i].clr; run = q[i].run; mem_ready = q[i].mr; operation = q[i].op;
      @(negedge clk);
      check_val($sformatf("cyc%0d_step%0d", i, q[i].exp[7:4]), 32'(obs), 32'(q[i].exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
